pe_psum_accumulator: RTL



---
 rtl/cnn_pkg.sv | 24 ++
 rtl/pe_psum_accumulator_if.sv | 26 ++
 rtl/psum_col_adder.sv | 22 ++
 rtl/pe_psum_accumulator.sv | 114 +++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and constants for the PE-matrix partial-sum datapath.
package cnn_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned PE_DIM = 11;
  localparam int unsigned PSUM_W = 2 * DATA_W + 7;

  typedef enum logic [1:0] {
    K3  = 2'b00,
    K5  = 2'b01,
    K7  = 2'b10,
    K11 = 2'b11
  } kmode_e;

  function automatic int unsigned ksize(kmode_e mode);
    unique case (mode)
      K3:      ksize = 3;
      K5:      ksize = 5;
      K7:      ksize = 7;
      default: ksize = 11;
    endcase
  endfunction

endpackage

// File: rtl/pe_psum_accumulator_if.sv
// Beat input and result output bundle between the PE matrix, accumulator and consumer.
interface pe_psum_accumulator_if
  import cnn_pkg::*;
#(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned AccWidth  = 32
);
  logic [1:0]                                   sel;
  logic [PE_DIM-1:0][PE_DIM-1:0][2*DataWidth-1:0] Bus_P;
  logic                                         in_valid;
  logic                                         in_last;
  logic                                         in_ready;
  logic [AccWidth-1:0]                          out_data;
  logic                                         out_valid;
  logic                                         out_ready;

  modport master (
    output sel, Bus_P, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  sel, Bus_P, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/psum_col_adder.sv
// Combinational sum of the first K products of one PE column; a disabled column sums to zero.
module psum_col_adder
  import cnn_pkg::*;
#(
  parameter int unsigned DataWidth = 8
) (
  input  logic [PE_DIM-1:0][2*DataWidth-1:0] col,
  input  logic [3:0]                         k,
  input  logic                               col_en,
  output logic [2*DataWidth+3:0]             sum
);
  localparam int unsigned ColW = 2 * DataWidth + 4;

  always_comb begin
    sum = '0;
    for (int unsigned r = 0; r < PE_DIM; r++) begin
      if (col_en && (4'(r) < k)) begin
        sum = sum + ColW'(col[r]);
      end
    end
  end
endmodule

// File: rtl/pe_psum_accumulator.sv
// Masked KxK window sum over the PE product bus, two-stage adder tree, channel accumulator
// with a valid/ready result port.
module pe_psum_accumulator
  import cnn_pkg::*;
#(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned AccWidth  = 32
) (
  input logic                   CLK,
  input logic                   RST,
  pe_psum_accumulator_if.slave  bus
);
  localparam int unsigned ColW = 2 * DataWidth + 4;
  localparam int unsigned PW   = 2 * DataWidth + 7;

  logic [3:0]                   k;
  logic [PE_DIM-1:0]            col_en;
  logic [PE_DIM-1:0][ColW-1:0]  col_sum;
  logic                         stall;
  logic [PW-1:0]                total;
  logic [AccWidth-1:0]          acc_next;

  logic [PE_DIM-1:0][ColW-1:0]  s1_sum_d, s1_sum_q;
  logic                         s1_valid_d, s1_valid_q, s1_last_d, s1_last_q;
  logic [PW-1:0]                s2_total_d, s2_total_q;
  logic                         s2_valid_d, s2_valid_q, s2_last_d, s2_last_q;
  logic [AccWidth-1:0]          acc_d, acc_q;
  logic                         first_d, first_q;
  logic [AccWidth-1:0]          out_data_d, out_data_q;
  logic                         out_valid_d, out_valid_q;

  assign k = 4'(ksize(kmode_e'(bus.sel)));

  for (genvar c = 0; c < PE_DIM; c++) begin : g_col
    assign col_en[c] = (4'(c) < k);
    psum_col_adder #(.DataWidth(DataWidth)) u_col (
      .col    (bus.Bus_P[c]),
      .k      (k),
      .col_en (col_en[c]),
      .sum    (col_sum[c])
    );
  end

  assign stall         = out_valid_q && !bus.out_ready;
  assign bus.in_ready  = !stall;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

  always_comb begin
    total = '0;
    for (int unsigned c = 0; c < PE_DIM; c++) begin
      total = total + PW'(s1_sum_q[c]);
    end
    acc_next = (first_q ? '0 : acc_q) + AccWidth'(s2_total_q);

    s1_sum_d    = s1_sum_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    s2_total_d  = s2_total_q;
    s2_valid_d  = s2_valid_q;
    s2_last_d   = s2_last_q;
    acc_d       = acc_q;
    first_d     = first_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !bus.out_ready;

    // The whole pipeline advances in lockstep; a held result freezes every stage.
    if (!stall) begin
      s1_sum_d   = col_sum;
      s1_valid_d = bus.in_valid;
      s1_last_d  = bus.in_valid && bus.in_last;
      s2_total_d = total;
      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;
      if (s2_valid_q) begin
        if (s2_last_q) begin
          out_data_d  = acc_next;
          out_valid_d = 1'b1;
          acc_d       = '0;
          first_d     = 1'b1;
        end else begin
          acc_d   = acc_next;
          first_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_sum_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_total_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      acc_q       <= '0;
      first_q     <= 1'b1;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s1_sum_q    <= s1_sum_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s2_total_q  <= s2_total_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      acc_q       <= acc_d;
      first_q     <= first_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule
